// File: rtl/rx_cpu_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_cpu_buf_if
// Brief    : FIFO-side and CPU-side signal bundle of the RX CPU prefetch buffer.
// Revision : 1.0
// ============================================================================
interface rx_cpu_buf_if #(
    parameter int CNT_W = 16
);
    logic             fifo_empty;
    logic [7:0]       fifo_q;
    logic             fifo_rd;
    logic             rd_byte;
    logic             rd_word;
    logic             clr_stat;
    logic [15:0]      data;
    logic             has_byte;
    logic             has_word;
    logic             underrun;
    logic [CNT_W-1:0] byte_count;

    // master: the environment (FIFO + CPU); slave: the buffer itself
    modport master (
        output fifo_empty, fifo_q, rd_byte, rd_word, clr_stat,
        input  fifo_rd, data, has_byte, has_word, underrun, byte_count
    );

    modport slave (
        input  fifo_empty, fifo_q, rd_byte, rd_word, clr_stat,
        output fifo_rd, data, has_byte, has_word, underrun, byte_count
    );
endinterface
`default_nettype wire

// File: rtl/rx_cpu_buf.sv
`default_nettype none
// ============================================================================
// Module   : rx_cpu_buf
// Brief    : Two-byte head/tail prefetch buffer from an FWFT RX FIFO to the CPU
//            read path. Optional delivered-byte counter: RX_CPU_BUF_COUNT_EN.
// Revision : 1.0
// ============================================================================
module rx_cpu_buf #(
    parameter int CNT_W = 16
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    rx_cpu_buf_if.slave   bus
);
    logic [7:0] r_u;
    logic [7:0] r_l;
    logic       r_u_full;
    logic       r_l_full;
    logic       r_underrun;

    logic [1:0] w_occ;
    logic [1:0] w_cons;
    logic [1:0] w_post;
    logic       w_word_ok;
    logic       w_byte_ok;
    logic       w_bad;
    logic       w_pop;
    logic [7:0] w_u_nxt;
    logic [7:0] w_l_nxt;
    logic       w_uf_nxt;
    logic       w_lf_nxt;

    // rd_word wins over rd_byte; a suppressed rd_byte is never an error
    always_comb begin
        w_occ     = {1'b0, r_u_full} + {1'b0, r_l_full};
        w_word_ok = bus.rd_word & r_l_full;
        w_byte_ok = ~bus.rd_word & bus.rd_byte & r_u_full;
        w_bad     = (bus.rd_word & ~r_l_full) | (~bus.rd_word & bus.rd_byte & ~r_u_full);
        w_cons    = w_word_ok ? 2'd2 : (w_byte_ok ? 2'd1 : 2'd0);
        w_post    = w_occ - w_cons;
        w_pop     = reset_n & ~bus.fifo_empty & (w_post < 2'd2);
    end

    always_comb begin
        w_u_nxt  = r_u;
        w_l_nxt  = r_l;
        w_uf_nxt = r_u_full;
        w_lf_nxt = r_l_full;
        if (w_word_ok) begin
            w_uf_nxt = 1'b0;
            w_lf_nxt = 1'b0;
        end else if (w_byte_ok) begin
            w_u_nxt  = r_l;
            w_uf_nxt = r_l_full;
            w_lf_nxt = 1'b0;
        end
        // refill lands in the first free slot after this cycle's consume
        if (w_pop) begin
            if (w_post == 2'd0) begin
                w_u_nxt  = bus.fifo_q;
                w_uf_nxt = 1'b1;
            end else begin
                w_l_nxt  = bus.fifo_q;
                w_lf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_u        <= 8'h00;
            r_l        <= 8'h00;
            r_u_full   <= 1'b0;
            r_l_full   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_u      <= w_u_nxt;
            r_l      <= w_l_nxt;
            r_u_full <= w_uf_nxt;
            r_l_full <= w_lf_nxt;
            if (w_bad) begin
                r_underrun <= 1'b1;
            end else if (bus.clr_stat) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign bus.fifo_rd  = w_pop;
    assign bus.data     = {r_u, r_l};
    assign bus.has_byte = r_u_full;
    assign bus.has_word = r_l_full;
    assign bus.underrun = r_underrun;

`ifdef RX_CPU_BUF_COUNT_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_sum;

    // the extra carry bit flags saturation; max+2 always fits in CNT_W+1 bits
    assign w_sum = {1'b0, r_count} + {{(CNT_W-1){1'b0}}, w_cons};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (bus.clr_stat) begin
            r_count <= '0;
        end else if (w_sum[CNT_W]) begin
            r_count <= C_CNT_MAX;
        end else begin
            r_count <= w_sum[CNT_W-1:0];
        end
    end

    assign bus.byte_count = r_count;
`else
    assign bus.byte_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_cpu_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_cpu_buf
// Brief    : Directed self-checking bench for rx_cpu_buf with FIFO model and
//            byte scoreboard.
// Revision : 1.0
// ============================================================================
module tb_rx_cpu_buf;
    localparam int CNT_W = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rx_cpu_buf_if #(.CNT_W(CNT_W)) bus ();

    rx_cpu_buf #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // FWFT FIFO model: pointer pair over a small memory
    logic [7:0] fifo_mem [0:63];
    logic [5:0] wr_ptr = 6'd0;
    logic [5:0] rd_ptr = 6'd0;
    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_q     = fifo_mem[rd_ptr];
    always @(posedge clk) if (bus.fifo_rd) rd_ptr <= rd_ptr + 6'd1;

    logic [7:0] sb [$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ec(input int v);
`ifdef RX_CPU_BUF_COUNT_EN
        return v;
`else
        return (v != 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 6'd1;
        sb.push_back(b);
    endtask

    // compare buffered bytes against the scoreboard just before a consume
    task automatic sb_take(input bit word);
        chk("sb_head", {24'd0, bus.data[15:8]}, {24'd0, sb[0]});
        void'(sb.pop_front());
        if (word) begin
            chk("sb_tail", {24'd0, bus.data[7:0]}, {24'd0, sb[0]});
            void'(sb.pop_front());
        end
    endtask

    task automatic strobe(input bit b, input bit w, input bit c);
        bus.rd_byte  = b;
        bus.rd_word  = w;
        bus.clr_stat = c;
        @(negedge clk);
        bus.rd_byte  = 1'b0;
        bus.rd_word  = 1'b0;
        bus.clr_stat = 1'b0;
    endtask

    task automatic wait_word(input int max_cyc);
        int k = 0;
        while (!bus.has_word && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk("wait_word", {31'd0, bus.has_word}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_byte  = 1'b0;
        bus.rd_word  = 1'b0;
        bus.clr_stat = 1'b0;
        push(8'hA5);
        push(8'h3C);
        @(negedge clk);
        chk("rst_data",  {16'd0, bus.data}, 32'h0);
        chk("rst_flags", {29'd0, bus.has_byte, bus.has_word, bus.underrun}, 32'd0);
        chk("rst_cnt",   {28'd0, bus.byte_count}, 32'd0);
        chk("rst_rd",    {31'd0, bus.fifo_rd}, 32'd0);

        reset_n = 1'b1;
        #1;
        chk("c0_rd", {31'd0, bus.fifo_rd}, 32'd1);
        @(negedge clk);
        chk("c1_hb", {30'd0, bus.has_byte, bus.has_word}, 32'b10);
        chk("c1_rd", {31'd0, bus.fifo_rd}, 32'd1);
        @(negedge clk);
        chk("c2_hw",   {31'd0, bus.has_word}, 32'd1);
        chk("c2_data", {16'd0, bus.data}, 32'h0000A53C);
        push(8'h11);
        #1;
        chk("c2_norefill", {31'd0, bus.fifo_rd}, 32'd0);
        @(negedge clk);
        chk("pops2", {26'd0, rd_ptr}, 32'd2);

        // byte read at occ=2 with simultaneous refill
        sb_take(1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        chk("rb_data", {16'd0, bus.data}, 32'h00003C11);
        chk("rb_hw",   {31'd0, bus.has_word}, 32'd1);
        chk("rb_cnt",  {28'd0, bus.byte_count}, ec(1));

        // drop to occ=1, then an invalid word read
        sb_take(1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        chk("occ1_flags", {30'd0, bus.has_byte, bus.has_word}, 32'b10);
        chk("occ1_u",     {24'd0, bus.data[15:8]}, 32'h11);
        strobe(1'b0, 1'b1, 1'b0);
        chk("ur_set",   {31'd0, bus.underrun}, 32'd1);
        chk("ur_state", {29'd0, bus.has_byte, bus.has_word, 1'b0}, 32'b100);
        chk("ur_u",     {24'd0, bus.data[15:8]}, 32'h11);
        chk("ur_cnt",   {28'd0, bus.byte_count}, ec(2));
        strobe(1'b0, 1'b0, 1'b1);
        chk("clr_ur",  {31'd0, bus.underrun}, 32'd0);
        chk("clr_cnt", {28'd0, bus.byte_count}, 32'd0);
        strobe(1'b0, 1'b1, 1'b1);
        chk("setwins", {31'd0, bus.underrun}, 32'd1);
        strobe(1'b0, 1'b0, 1'b1);
        chk("clr_ur2", {31'd0, bus.underrun}, 32'd0);

        // both strobes at occ=2: word wins, no error
        push(8'h22);
        wait_word(4);
        sb_take(1'b1);
        strobe(1'b1, 1'b1, 1'b0);
        chk("both_ur",  {31'd0, bus.underrun}, 32'd0);
        chk("both_hb",  {31'd0, bus.has_byte}, 32'd0);
        chk("both_cnt", {28'd0, bus.byte_count}, ec(2));

        // climb to 14, then saturate at 15
        for (int i = 0; i < 8; i++) begin
            push(8'h40 + 8'(2 * i));
            push(8'h41 + 8'(2 * i));
            wait_word(4);
            sb_take(1'b1);
            strobe(1'b0, 1'b1, 1'b0);
            if (i == 5) chk("cnt14", {28'd0, bus.byte_count}, ec(14));
            if (i == 6) chk("cnt15", {28'd0, bus.byte_count}, ec(15));
            if (i == 7) chk("cnt_sat", {28'd0, bus.byte_count}, ec(15));
        end

        // asynchronous reset with a pop pending
        push(8'h77);
        push(8'h88);
        push(8'h99);
        wait_word(4);
        bus.rd_byte = 1'b1;
        #1;
        chk("pre_rst_rd", {31'd0, bus.fifo_rd}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_data",  {16'd0, bus.data}, 32'h0);
        chk("arst_flags", {29'd0, bus.has_byte, bus.has_word, bus.underrun}, 32'd0);
        chk("arst_rd",    {31'd0, bus.fifo_rd}, 32'd0);
        begin
            logic [5:0] held;
            held = rd_ptr;
            @(posedge clk);
            #2;
            chk("arst_nopop", {26'd0, rd_ptr}, {26'd0, held});
        end
        @(negedge clk);
        bus.rd_byte = 1'b0;
        sb.delete();
        for (logic [5:0] p = rd_ptr; p != wr_ptr; p++) sb.push_back(fifo_mem[p]);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_hb", {31'd0, bus.has_byte}, 32'd1);
        chk("post_rst_cnt", {28'd0, bus.byte_count}, 32'd0);
        sb_take(1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        chk("post_rst_empty", {31'd0, bus.has_byte}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rx_cpu_buf.md
# rx_cpu_buf

Two-byte prefetch buffer between the receive byte FIFO and the CPU bus read path; the receive-side counterpart of the CPU transmit buffer. Pops bytes from a first-word-fall-through FIFO into a head/tail register pair so the CPU can take either one byte or a 16-bit word per read strobe. Flags reads that find too few bytes in the buffer, and optionally counts delivered bytes.

## Interface
- `CNT_W`, default 16: width of `byte_count`; 2 ≤ `CNT_W` ≤ 32.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  RX FIFO has no byte.
- `fifo_q`  in  8  RX FIFO head byte; valid whenever `!fifo_empty` (FWFT).
- `fifo_rd`  out  1  pop strobe to the FIFO; combinational.
- `rd_byte`  in  1  CPU consumes the head byte.
- `rd_word`  in  1  CPU consumes the head and tail bytes.
- `clr_stat`  in  1  clears `underrun` and `byte_count`.
- `data`  out  16  `{u, l}`; `u` is the head (older) byte, in bits [15:8].
- `has_byte`  out  1  `u_full`.
- `has_word`  out  1  `l_full`.
- `underrun`  out  1  sticky flag: an invalid read was attempted.
- `byte_count`  out  `CNT_W`  count of delivered bytes (see Configuration).

## Operation
- State: `u`, `l` (8 bits each), `u_full`, `l_full`.
  - Invariant: `l_full` implies `u_full`. The state `u_full=0`, `l_full=1` must never occur.
  - Occupancy `occ` = `u_full` + `l_full`, range 0..2.
- Read arbitration:
  - `rd_word` has precedence. If `rd_word` and `rd_byte` are both high, `rd_byte` is ignored and raises no error.
  - A word read is valid only if `l_full`. It consumes 2 bytes.
  - A byte read is valid only if `u_full`. It consumes 1 byte: `l` shifts into `u`, and `l_full` shifts into `u_full`.
  - An invalid read changes no buffer state and sets `underrun`.
- Refill:
  - `post` = `occ` minus bytes consumed this cycle.
  - `fifo_rd` = `reset_n & !fifo_empty & (post < 2)`.
  - On a pop, `fifo_q` is written into slot `u` if `post` = 0, or slot `l` if `post` = 1.
  - At most one pop per cycle.
- Simultaneous read and refill in the same cycle are legal. Example: `occ` = 2, `rd_byte`, FIFO not empty → `u` ← old `l`, `l` ← `fifo_q`, `occ` stays 2.
- `clr_stat`: if an underrun occurs in the same cycle as `clr_stat`, the set wins and `underrun` = 1.
- Reset (`reset_n` low, at any time including mid-transfer):
  - All flags 0, `u` = `l` = 0, so `data` = 16'h0000.
  - `has_byte` = `has_word` = `underrun` = 0, `byte_count` = 0, `fifo_rd` = 0.
  - Bytes held in the buffer are discarded. The FIFO is not popped.

## Timing
- `data`, `has_byte`, `has_word` and `underrun` are registered. `fifo_rd` is combinational from the current state and inputs.
- Latency from FIFO to CPU: a byte popped in cycle N is visible on `data` and `has_byte` in cycle N+1.
- From empty with a continuously non-empty FIFO: `has_byte` at N+1, `has_word` at N+2.
- Read strobes are single-cycle and sampled on each edge. The CPU samples `data` before asserting a strobe; a strobe held high consumes again every cycle.
- Sustained throughput: 1 byte/cycle (a byte read each cycle with a non-empty FIFO). Sustained word reads: 1 word every 2 cycles.

## Configuration
- `RX_CPU_BUF_COUNT_EN` defined:
  - `byte_count` increments by 1 on a valid byte read and by 2 on a valid word read.
  - Saturates at 2^`CNT_W`−1; never wraps. An increment of 2 from max−1 lands at max.
  - `clr_stat` clears it to 0; a consume in the same cycle as `clr_stat` is not counted.
- `RX_CPU_BUF_COUNT_EN` undefined:
  - `byte_count` is driven constant 0 and no counter logic exists.
  - All other behaviour is identical.

## Test plan
- Reset with FIFO holding 8'hA5, 8'h3C, then release → `fifo_rd` high in cycles 0 and 1; `has_byte` at 1; `has_word` and `data` = 16'hA53C at 2; no third pop.
- At `occ` = 2 with FIFO holding 8'h11: `rd_byte` → next cycle `data[15:8]` = 8'h3C, `l` = 8'h11, `occ` = 2, `byte_count` = 1 (with macro).
- `occ` = 1, `rd_word` → state unchanged, `underrun` = 1. Then `clr_stat` → `underrun` = 0.
- `rd_byte` and `rd_word` together at `occ` = 2 → 2 bytes consumed, `underrun` stays 0, `byte_count` +2.
- With `CNT_W` = 4, count at 14: `rd_word` → 15; another `rd_word` → 15. Without the macro → 0 throughout.
- Assert `reset_n` low while `occ` = 2 and `fifo_rd` high → all outputs 0 immediately (asynchronous), no pop on the following edge.
